mem_access_ctrl: RTL and testbench

Memory access controller sitting directly downstream of the ALU. Consumes the ALU's MemIO command, address and data; runs a req/ack handshake to the data memory; returns read data to the general registers together with the ALU's ValidMemData strobe. Also forwards register-writeback commands (MemIO = 11) and stalls the fetch/decode path while a memory transaction is in flight.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_timeout_cnt.sv | 33 +++
 rtl/mem_access_ctrl.sv | 113 +++++++++++
 tb/tb_mem_access_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory access controller: ALU MemIO commands,
// controller states and default widths.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        MIO_NOP = 2'b00,
        MIO_RD  = 2'b01,
        MIO_WR  = 2'b10,
        MIO_GR  = 2'b11
    } mem_io_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Cycle counter for an outstanding memory request; expire is asserted on the
// TIMEOUT-th enabled cycle so the owner can abandon the request on that edge.
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The count holds the number of edges already spent in ACCESS, so the
    // edge that sees LAST is the TIMEOUT-th one.
    assign expire = en && !clear && (cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// ALU-to-data-memory access controller: req/ack handshake, read data return
// to the general registers, register writeback forwarding and fetch stall.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mem_io,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              gr_we,
    output logic [DATA_W-1:0] gr_wdata,
    output logic              valid_mem_data,
    output logic              busy,
    output logic              mem_err
);

    // Handshake: mem_req rises with latched addr/data/we and holds them
    // unchanged until the edge that samples mem_ack (one-cycle pulse) or the
    // timeout edge; acks seen outside ACCESS belong to nothing and are dropped.

    state_e            state;
    logic [DATA_W-1:0] rdata_q;
    logic              expire;

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != ST_ACCESS),
        .en     (state == ST_ACCESS),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rdata_q        <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            gr_we          <= 1'b0;
            gr_wdata       <= '0;
            valid_mem_data <= 1'b0;
            busy           <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            gr_we          <= 1'b0;
            valid_mem_data <= 1'b0;
            mem_err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (mem_io)
                        MIO_RD, MIO_WR: begin
                            mem_addr  <= alu_addr;
                            mem_wdata <= alu_data;
                            mem_we    <= (mem_io == MIO_WR);
                            mem_req   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_ACCESS;
                        end
                        MIO_GR: begin
                            gr_we    <= 1'b1;
                            gr_wdata <= alu_data;
                        end
                        default: ;
                    endcase
                end
                ST_ACCESS: begin
                    // An ack on the expiry edge still completes the access.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            rdata_q <= mem_rdata;
                            state   <= ST_RESP;
                        end
                    end else if (expire) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    gr_we          <= 1'b1;
                    gr_wdata       <= rdata_q;
                    valid_mem_data <= 1'b1;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scenario bench for mem_access_ctrl with a writeback scoreboard and a
// request-phase monitor.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic [1:0]    mem_io;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          gr_we;
    logic [DW-1:0] gr_wdata;
    logic          valid_mem_data;
    logic          busy;
    logic          mem_err;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_io         (mem_io),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .gr_we          (gr_we),
        .gr_wdata       (gr_wdata),
        .valid_mem_data (valid_mem_data),
        .busy           (busy),
        .mem_err        (mem_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / monitor ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    int   n_req = 0, n_txn = 0, n_gr = 0, n_valid = 0, n_err = 0;
    logic prev_req = 1'b0;
    logic mon_chk = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic          exp_we = 1'b0;
    logic [DW-1:0] exp_gr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                n_req++;
                if (!prev_req) n_txn++;
            end
            prev_req = mem_req;
            if (mem_err) n_err++;
            if (valid_mem_data) n_valid++;
            if (gr_we) begin
                n_gr++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL gr_unexpected: gr_we=1 gr_wdata=%h, expected no writeback", gr_wdata);
                end else begin
                    exp_gr = exp_q.pop_front();
                    if (gr_wdata !== exp_gr) begin
                        errors++;
                        $display("FAIL gr_wdata: got %h expected %h", gr_wdata, exp_gr);
                    end
                end
            end
            if (mem_req && mon_chk) begin
                checks++;
                if ({mem_addr, mem_wdata, mem_we} !== {exp_addr, exp_wdata, exp_we}) begin
                    errors++;
                    $display("FAIL req_fields: got addr=%h wdata=%h we=%b expected addr=%h wdata=%h we=%b",
                             mem_addr, mem_wdata, mem_we, exp_addr, exp_wdata, exp_we);
                end
            end
        end else begin
            prev_req = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_io   = cmd;
        alu_addr = a;
        alu_data = d;
        step(1);
        mem_io = MIO_NOP;
    endtask

    task automatic set_exp(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        mon_chk   = 1'b1;
        exp_addr  = a;
        exp_wdata = d;
        exp_we    = we;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; mem_io = MIO_NOP; alu_addr = '0; alu_data = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        step(3);
        checks++;
        if ({mem_req, mem_we, gr_we, valid_mem_data, busy, mem_err} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || gr_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b gr_we=%b valid=%b busy=%b err=%b addr=%h wdata=%h gr=%h, expected all 0",
                     mem_req, mem_we, gr_we, valid_mem_data, busy, mem_err, mem_addr, mem_wdata, gr_wdata);
        end
        @(negedge clk) rst_n = 1'b1;
        step(2);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b mem_req=%b expected 0 0", busy, mem_req);
        end
    endtask

    task automatic test_read();
        int g0, v0, t0, r0;
        g0 = n_gr; v0 = n_valid; t0 = n_txn; r0 = n_req;
        set_exp(32'h100, 32'h0, 1'b0);
        exp_q.push_back(32'hDEADBEEF);
        issue(MIO_RD, 32'h100, 32'h0);
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL read_req: req=%b busy=%b we=%b addr=%h expected 1 1 0 00000100", mem_req, busy, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step(1);
        mem_ack = 1'b0; mem_rdata = '0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b1 || gr_we !== 1'b0) begin
            errors++;
            $display("FAIL read_resp_phase: req=%b busy=%b gr_we=%b expected 0 1 0", mem_req, busy, gr_we);
        end
        step(1);
        checks++;
        if (gr_we !== 1'b1 || valid_mem_data !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_valid: gr_we=%b valid=%b busy=%b expected 1 1 0", gr_we, valid_mem_data, busy);
        end
        step(1);
        @(negedge clk);
        checks++;
        if (n_gr - g0 != 1 || n_valid - v0 != 1 || n_txn - t0 != 1 || n_req - r0 != 1) begin
            errors++;
            $display("FAIL read_counts: gr=%0d valid=%0d txn=%0d req_cycles=%0d expected 1 1 1 1",
                     n_gr - g0, n_valid - v0, n_txn - t0, n_req - r0);
        end
    endtask

    task automatic test_write_wait3();
        int g0, e0, r0;
        g0 = n_gr; e0 = n_err; r0 = n_req;
        set_exp(32'h20, 32'h12345678, 1'b1);
        issue(MIO_WR, 32'h20, 32'h12345678);
        alu_addr = 32'hFFFF_FFFF; alu_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL write_hold[%0d]: req=%b we=%b busy=%b expected 1 1 1", i, mem_req, mem_we, busy);
            end
            step(1);
        end
        // Ack lands on the same edge the timeout would fire (TIMEOUT=4).
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL write_done: req=%b busy=%b err=%b expected 0 0 0", mem_req, busy, mem_err);
        end
        @(negedge clk);
        checks++;
        if (n_req - r0 != 4 || n_gr != g0 || n_err != e0) begin
            errors++;
            $display("FAIL write_counts: req_cycles=%0d gr=%0d err=%0d expected 4 0 0", n_req - r0, n_gr - g0, n_err - e0);
        end
    endtask

    task automatic test_writeback();
        int t0;
        t0 = n_txn;
        mon_chk = 1'b0;
        exp_q.push_back(32'h55);
        issue(MIO_GR, 32'h0, 32'h55);
        checks++;
        if (gr_we !== 1'b1 || gr_wdata !== 32'h55 || busy !== 1'b0 || mem_req !== 1'b0 || valid_mem_data !== 1'b0) begin
            errors++;
            $display("FAIL writeback: gr_we=%b gr=%h busy=%b req=%b valid=%b expected 1 00000055 0 0 0",
                     gr_we, gr_wdata, busy, mem_req, valid_mem_data);
        end
        step(1);
        @(negedge clk);
        checks++;
        if (n_txn != t0 || gr_we !== 1'b0) begin
            errors++;
            $display("FAIL writeback_after: txn=%0d gr_we=%b expected 0 0", n_txn - t0, gr_we);
        end
    endtask

    task automatic test_timeout();
        int g0, v0, e0, r0, waited;
        g0 = n_gr; v0 = n_valid; e0 = n_err; r0 = n_req;
        set_exp(32'h40, 32'h0, 1'b0);
        issue(MIO_RD, 32'h40, 32'h0);
        waited = 0;
        while (mem_req === 1'b1 && waited < 20) begin
            step(1);
            waited++;
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_bound: mem_req still %b after %0d cycles, expected 0", mem_req, waited);
        end
        checks++;
        if (mem_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b busy=%b expected 1 0", mem_err, busy);
        end
        step(1);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        step(1);
        mem_ack = 1'b0; mem_rdata = '0;
        step(3);
        @(negedge clk);
        checks++;
        if (n_req - r0 != 4 || n_err - e0 != 1 || n_valid != v0 || n_gr != g0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_counts: req_cycles=%0d err=%0d valid=%0d gr=%0d busy=%b expected 4 1 0 0 0",
                     n_req - r0, n_err - e0, n_valid - v0, n_gr - g0, busy);
        end
    endtask

    task automatic test_cmd_while_busy();
        int t0, r0, g0;
        t0 = n_txn; r0 = n_req; g0 = n_gr;
        set_exp(32'h80, 32'h0, 1'b0);
        exp_q.push_back(32'hA5A5_A5A5);
        issue(MIO_RD, 32'h80, 32'h0);
        mem_io = MIO_RD; alu_addr = 32'h99; alu_data = 32'h77;
        step(2);
        mem_io = MIO_NOP;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        step(1);
        mem_ack = 1'b0; mem_rdata = '0;
        step(1);
        checks++;
        if (gr_we !== 1'b1 || valid_mem_data !== 1'b1) begin
            errors++;
            $display("FAIL busy_read_valid: gr_we=%b valid=%b expected 1 1", gr_we, valid_mem_data);
        end
        step(3);
        @(negedge clk);
        checks++;
        if (n_txn - t0 != 1 || n_req - r0 != 3 || n_gr - g0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: txn=%0d req_cycles=%0d gr=%0d busy=%b expected 1 3 1 0",
                     n_txn - t0, n_req - r0, n_gr - g0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = n_txn;
        set_exp(32'h10, 32'h1111, 1'b1);
        issue(MIO_WR, 32'h10, 32'h1111);
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_write_done: busy=%b req=%b expected 0 0", busy, mem_req);
        end
        set_exp(32'h14, 32'h2222, 1'b0);
        exp_q.push_back(32'h3333_4444);
        issue(MIO_RD, 32'h14, 32'h2222);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h14) begin
            errors++;
            $display("FAIL b2b_read_req: req=%b we=%b addr=%h expected 1 0 00000014", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        step(1);
        mem_ack = 1'b0; mem_rdata = '0;
        step(1);
        checks++;
        if (gr_we !== 1'b1 || valid_mem_data !== 1'b1) begin
            errors++;
            $display("FAIL b2b_read_valid: gr_we=%b valid=%b expected 1 1", gr_we, valid_mem_data);
        end
        step(1);
        @(negedge clk);
        checks++;
        if (n_txn - t0 != 2) begin
            errors++;
            $display("FAIL b2b_txn: txn=%0d expected 2", n_txn - t0);
        end
    endtask

    task automatic test_reset_mid_access();
        int g0;
        mon_chk = 1'b0;
        issue(MIO_RD, 32'h200, 32'h0);
        step(1);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, gr_we, valid_mem_data, busy, mem_err} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mid: req=%b we=%b gr_we=%b valid=%b busy=%b err=%b addr=%h expected all 0",
                     mem_req, mem_we, gr_we, valid_mem_data, busy, mem_err, mem_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        step(1);
        g0 = n_gr;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step(1);
        mem_ack = 1'b0; mem_rdata = '0;
        step(2);
        checks++;
        if (n_gr != g0 || gr_we !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_late_ack: gr=%0d gr_we=%b busy=%b req=%b expected 0 0 0 0", n_gr - g0, gr_we, busy, mem_req);
        end
        set_exp(32'h300, 32'h0, 1'b0);
        exp_q.push_back(32'hCAFE_F00D);
        issue(MIO_RD, 32'h300, 32'h0);
        step(1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step(1);
        mem_ack = 1'b0; mem_rdata = '0;
        step(1);
        checks++;
        if (gr_we !== 1'b1 || valid_mem_data !== 1'b1) begin
            errors++;
            $display("FAIL reset_next_read: gr_we=%b valid=%b expected 1 1", gr_we, valid_mem_data);
        end
        step(1);
        @(negedge clk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_read();
        test_write_wait3();
        test_writeback();
        test_timeout();
        test_cmd_while_busy();
        test_back_to_back();
        test_reset_mid_access();
        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d writebacks outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
